// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers and default thresholds for sync_fifo
package sync_fifo_pkg;

  localparam int DEF_DSIZE         = 8;
  localparam int DEF_ASIZE         = 4;
  localparam int DEF_AEMPTY_THRESH = 1;

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO (DEPTH) is representable.
  function automatic int cnt_w(input int asize);
    return asize + 1;
  endfunction

  function automatic int afull_default(input int asize);
    return (1 << asize) - 2;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - storage array, one clocked write port and one asynchronous read port
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [depth_of(ASIZE)];

  // Contents are intentionally not reset; reads are qualified by deq_valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with flush, occupancy and optional sticky error flags (SYNC_FIFO_ERR_FLAGS_EN)
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE         = DEF_DSIZE,
  parameter int ASIZE         = DEF_ASIZE,
  parameter int AFULL_THRESH  = afull_default(ASIZE),
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] enq_bits,
  input  logic             enq_valid,
  output logic             enq_ready,
  output logic [DSIZE-1:0] deq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  input  logic             flush,
  output logic [ASIZE:0]   count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int            CW      = cnt_w(ASIZE);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(ASIZE));
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

  logic [CW-1:0] wptr, rptr, count_q;
  logic          enq_fire, deq_fire;

  assign enq_ready    = (count_q != DEPTH_C);
  assign deq_valid    = (count_q != '0);
  assign enq_fire     = enq_valid & enq_ready;
  assign deq_fire     = deq_valid & deq_ready;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) wptr <= wptr + 1'b1;
      if (deq_fire) rptr <= rptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A flushed write must not land in memory, so the write strobe is masked by flush.
  sync_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk   (clk),
    .we    (enq_fire & ~flush),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (enq_bits),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (deq_bits)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (enq_valid & ~enq_ready) ovf_q <= 1'b1;
      if (deq_ready & ~deq_valid) udf_q <= 1'b1;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo at DEPTH=4
module tb_sync_fifo;

  localparam int DSIZE = 8;
  localparam int ASIZE = 2;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DSIZE-1:0] enq_bits;
  logic             enq_valid;
  logic             enq_ready;
  logic [DSIZE-1:0] deq_bits;
  logic             deq_valid;
  logic             deq_ready;
  logic             flush;
  logic [ASIZE:0]   count;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow_err;
  logic             underflow_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [DSIZE-1:0] sb[$];

  sync_fifo #(
    .DSIZE         (DSIZE),
    .ASIZE         (ASIZE),
    .AFULL_THRESH  (3),
    .AEMPTY_THRESH (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enq_bits      (enq_bits),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .deq_bits      (deq_bits),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .flush         (flush),
    .count         (count),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DSIZE-1:0] d);
    enq_bits  = d;
    enq_valid = 1'b1;
    sb.push_back(d);
    cyc();
    enq_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    deq_ready = 1'b1;
    repeat (n) cyc();
    deq_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_enq_ready"}, int'(enq_ready), 1);
    check({tag, "_deq_valid"}, int'(deq_valid), 0);
    check({tag, "_almost_empty"}, int'(almost_empty), 1);
    check({tag, "_almost_full"}, int'(almost_full), 0);
  endtask

  // Monitor: a read fires at the next rising edge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (rst_n && !flush && deq_valid && deq_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL deq_unexpected: got %0h want none", deq_bits);
      end else begin
        check("deq_bits", int'(deq_bits), int'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; enq_bits = '0; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    cyc(); cyc();
    check_reset_outputs("rst");
    check("rst_ovf", int'(overflow_err), 0);
    check("rst_udf", int'(underflow_err), 0);
    rst_n = 1'b1;
    cyc();

    // Fill to full, then read back in order.
    for (int i = 0; i < 4; i++) begin
      put(8'hA1 + 8'(i));
      check("fill_count", int'(count), i + 1);
      check("fill_afull", int'(almost_full), (i + 1 >= 3) ? 1 : 0);
      check("fill_aempty", int'(almost_empty), (i + 1 <= 1) ? 1 : 0);
      check("fill_enq_ready", int'(enq_ready), (i + 1 != 4) ? 1 : 0);
    end
    drain(4);
    check("drain_count", int'(count), 0);
    check("drain_deq_valid", int'(deq_valid), 0);

    // Full FIFO with enq and deq together: only the read fires.
    for (int i = 0; i < 4; i++) put(8'hB1 + 8'(i));
    enq_bits = 8'hBF; enq_valid = 1'b1; deq_ready = 1'b1;
    cyc();
    enq_valid = 1'b0; deq_ready = 1'b0;
    check("fullrw_count", int'(count), 3);
    check("fullrw_enq_ready", int'(enq_ready), 1);
    drain(3);
    check("fullrw_drain_count", int'(count), 0);

    // Steady simultaneous traffic at count 2 across pointer wrap.
    put(8'hC0); put(8'hC1);
    for (int i = 0; i < 10; i++) begin
      enq_bits = 8'hC2 + 8'(i); enq_valid = 1'b1; deq_ready = 1'b1;
      sb.push_back(enq_bits);
      cyc();
      check("steady_count", int'(count), 2);
    end
    enq_valid = 1'b0;
    drain(2);
    check("steady_drain_count", int'(count), 0);

    // Flush with a concurrent enq: nothing survives.
    put(8'hD1); put(8'hD2); put(8'hD3);
    enq_bits = 8'hDE; enq_valid = 1'b1; flush = 1'b1;
    cyc();
    enq_valid = 1'b0; flush = 1'b0;
    sb.delete();
    check("flush_count", int'(count), 0);
    check("flush_deq_valid", int'(deq_valid), 0);
    put(8'h5A);
    check("postflush_deq_bits", int'(deq_bits), 8'h5A);
    drain(1);

    // Sticky error flags.
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
    check("udf_set", int'(underflow_err), int'(ERR_EXP));
    for (int i = 0; i < 4; i++) put(8'hE1 + 8'(i));
    enq_bits = 8'hEF; enq_valid = 1'b1;
    cyc();
    enq_valid = 1'b0;
    check("ovf_set", int'(overflow_err), int'(ERR_EXP));
    cyc();
    check("ovf_hold", int'(overflow_err), int'(ERR_EXP));
    check("udf_hold", int'(underflow_err), int'(ERR_EXP));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    sb.delete();
    check("err_flush_ovf", int'(overflow_err), 0);
    check("err_flush_udf", int'(underflow_err), 0);
    check("err_flush_count", int'(count), 0);

    // Asynchronous reset mid-burst.
    put(8'hF1); put(8'hF2);
    enq_bits = 8'hF3; enq_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    enq_valid = 1'b0;
    sb.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    put(8'h77);
    check("arst_next_valid", int'(deq_valid), 1);
    check("arst_next_count", int'(count), 1);
    check("arst_next_bits", int'(deq_bits), 8'h77);
    drain(1);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
